// File: rtl/wb_writer.sv
// wb_writer: MEM/WB write-back stage that drives the register-file write port,
// stalling MEM while a load waits on SRAM, with flush, load timeout and retire counting.
module wb_writer #(
    parameter int NUM_REGS     = 12,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic        mem_load,
    input  logic [3:0]  mem_waddr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ready,
    input  logic        flush,
    output logic        stall_req,
    output logic [15:0] regData,
    output logic [3:0]  regAddr,
    output logic        we,
    output logic [15:0] retire_cnt,
    output logic        bad_addr,
    output logic        load_timeout
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [4:0]  NR     = 5'(NUM_REGS);
    localparam logic [15:0] TMO_M1 = 16'(LOAD_TIMEOUT - 1);

    state_t      state, state_n;
    logic [3:0]  laddr;
    logic [15:0] wcnt;
    logic        in_legal, l_legal, acc, go_wait, imm, done, tmo, imm_wr, ld_wr;

    always_comb begin
        in_legal  = {1'b0, mem_waddr} < NR;
        l_legal   = {1'b0, laddr} < NR;
        acc       = (state == IDLE) & mem_valid & ~flush;
        go_wait   = acc & mem_load & mem_we;
        imm       = acc & ~(mem_load & mem_we);
        done      = (state == WAIT) & ram_ready & ~flush;
        tmo       = (state == WAIT) & ~ram_ready & ~flush & (wcnt >= TMO_M1);
        imm_wr    = imm & mem_we & in_legal;
        ld_wr     = done & l_legal;
        stall_req = (state == WAIT) & ~ram_ready & ~flush;
        state_n   = go_wait ? WAIT
                  : ((state == WAIT) & (ram_ready | flush | tmo)) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            regData      <= '0;
            regAddr      <= '0;
            we           <= 1'b0;
            retire_cnt   <= '0;
            bad_addr     <= 1'b0;
            load_timeout <= 1'b0;
            laddr        <= '0;
            wcnt         <= '0;
        end else begin
            state <= state_n;
            we    <= imm_wr | ld_wr;
            if (imm_wr) begin
                regAddr <= mem_waddr;
                regData <= mem_wdata;
            end else if (ld_wr) begin
                regAddr <= laddr;
                regData <= ram_rdata;
            end
            if (imm | done | tmo) retire_cnt <= retire_cnt + 16'd1;
            if (acc & mem_we & ~in_legal) bad_addr <= 1'b1;
            if (tmo) load_timeout <= 1'b1;
            if (go_wait) begin
                laddr <= mem_waddr;
                wcnt  <= '0;
            end else if (state == WAIT) begin
                wcnt <= wcnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- MEM/WB write-back stage: the producer side of the register file's write port (regData, regAddr, we).
- Accepts retiring results from the MEM stage; waits on SRAM for load data.
- Issues exactly one single-cycle write per retiring register-writing instruction.
- Raises a stall request while a load is outstanding; supports flush, load timeout and retire counting.

Parameters:
- NUM_REGS, 12: number of architectural registers; write addresses >= NUM_REGS are illegal.
- LOAD_TIMEOUT, 255: maximum cycles to wait for ram_ready before abandoning a load (1..65535).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- mem_valid  in  1  MEM stage presents a retiring instruction this cycle.
- mem_we  in  1  instruction writes a register.
- mem_load  in  1  result comes from memory (ram_rdata), not mem_wdata.
- mem_waddr  in  4  destination register.
- mem_wdata  in  16  ALU/move result for non-load instructions.
- ram_rdata  in  16  load data, valid when ram_ready=1.
- ram_ready  in  1  load data valid strobe.
- flush  in  1  discard the instruction accepted or pending this cycle.
- stall_req  out  1  hold the MEM stage; combinational.
- regData  out  16  write data to the register file.
- regAddr  out  4  write address to the register file.
- we  out  1  write enable; single-cycle pulse.
- retire_cnt  out  16  count of retired instructions.
- bad_addr  out  1  sticky: illegal write address seen.
- load_timeout  out  1  sticky: a load was abandoned on timeout.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; regData=0, regAddr=0, we=0, retire_cnt=0, bad_addr=0, load_timeout=0; wait counter=0.
  - Reset during WAIT abandons the load with no write.
- States: IDLE, WAIT.
- IDLE, mem_valid=1, flush=0, mem_load=0 or mem_we=0:
  - Next edge: we=mem_we and addr legal; regAddr=mem_waddr; regData=mem_wdata.
  - retire_cnt+1. Latency is 1 cycle.
- IDLE, mem_valid=1, flush=0, mem_load=1, mem_we=1:
  - Latch mem_waddr; clear the wait counter; next state WAIT. No write this edge.
- IDLE, flush=1: input ignored; no write, no count.
- WAIT:
  - stall_req = (state==WAIT) & ~ram_ready & ~flush.
  - mem_valid is ignored (upstream is stalled).
  - Wait counter increments each cycle.
- WAIT, ram_ready=1, flush=0:
  - Next edge: we=1 (if addr legal), regAddr=latched addr, regData=ram_rdata, retire_cnt+1; state IDLE.
  - The next instruction may be accepted from the following cycle.
- WAIT, flush=1: state IDLE; no write, no count; flush wins over a simultaneous ram_ready.
- WAIT, counter reaches LOAD_TIMEOUT without ram_ready:
  - state IDLE; no write; load_timeout set; retire_cnt+1.
  - A late ram_ready seen in IDLE is ignored.
- Illegal address (mem_waddr >= NUM_REGS) with a write requested:
  - we stays 0; bad_addr set (sticky until reset).
  - Instruction still counts as retired; loads still wait for data.
- we is high for exactly one cycle per write.
- regData and regAddr hold their last values while we=0.
- retire_cnt wraps 16'hFFFF -> 16'h0000.
- Width rules:
  - mem_waddr is compared against NUM_REGS zero-extended.
  - Wait counter is 16 bits; compare is >=.

Test Plan:
1. Reset, then mem_valid=1, mem_we=1, mem_load=0, mem_waddr=3, mem_wdata=16'h1234 for one cycle -> next cycle we=1, regAddr=3, regData=16'h1234; following cycle we=0; retire_cnt=1.
2. Load to r5, ram_ready asserted 3 cycles later with ram_rdata=16'hBEEF -> stall_req=1 for 2 cycles, 0 in the ram_ready cycle; next edge we=1, regAddr=5, regData=16'hBEEF, retire_cnt+1.
3. Load pending, flush and ram_ready asserted together -> no we pulse; state IDLE; retire_cnt unchanged; stall_req=0 that cycle.
4. LOAD_TIMEOUT=4, load with no ram_ready -> after 4 wait cycles state returns to IDLE; load_timeout=1; we never pulses; a later ram_ready produces no write.
5. Write to mem_waddr=13 -> we stays 0; bad_addr=1 and remains 1 after further legal writes, until rst=0.
6. Preload retire_cnt to 16'hFFFF via back-to-back writes, retire one more -> retire_cnt=0. Then hold rst=0 mid-WAIT -> all outputs 0, no write when rst returns to 1.
